conv2d_linebuf_param: RTL

CONV2D_LINEBUF_PARAM -- requirements
Module: conv2d_linebuf_param

---
 rtl/conv2d_linebuf_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv2d_linebuf_param.sv
// 3x3 valid stride-1 convolution over a raster pixel stream using two line buffers
// and a 3x3 window; weights are taken from the first nine samples of each frame.
//
// state | meaning
// IDLE  | waiting for the first sample of a frame
// RUN   | accepting pixels of the current frame
// DRAIN | last pixel taken, flushing the 2-stage pipeline; inputs dropped
module conv2d_linebuf_param #(
  parameter int DW     = 16,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_ifm,
  input  logic [DW-1:0]     in_weight,
  output logic              out_valid,
  output logic [2*DW+3:0]   out_ofm,
  output logic              frame_done,
  output logic              err
);
  localparam int OW = 2*DW+4;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic            drain_cnt_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [3:0]      wcnt_q;
  logic [DW-1:0]   wts_q [9];
  logic [DW-1:0]   win_q [9];
  logic [DW-1:0]   lb1_q [IMG_W];
  logic [DW-1:0]   lb2_q [IMG_W];
  logic            fire_q, v1_q;
  logic [OW-1:0]   sum_q, sum_d;
  logic            accept, last_px;

  assign accept  = in_valid && (state_q != DRAIN);
  assign last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Operands widened by one bit so one signed multiplier covers both modes.
  function automatic logic signed [2*DW+1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] ea, eb;
    ea = {(SIGNED != 0) ? a[DW-1] : 1'b0, a};
    eb = {(SIGNED != 0) ? b[DW-1] : 1'b0, b};
    return ea * eb;
  endfunction

  always_comb begin
    logic signed [OW-1:0] p;
    p     = '0;
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      p     = mul(win_q[k], wts_q[k]);
      sum_d = sum_d + p;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (accept && last_px) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      wcnt_q      <= '0;
      fire_q      <= 1'b0;
      v1_q        <= 1'b0;
      sum_q       <= '0;
      out_valid   <= 1'b0;
      out_ofm     <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        wts_q[k] <= '0;
        win_q[k] <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (wcnt_q != 4'd9) begin
          wts_q[wcnt_q] <= in_weight;
          wcnt_q        <= wcnt_q + 4'd1;
        end
        lb1_q[col_q] <= in_ifm;
        lb2_q[col_q] <= lb1_q[col_q];
        // window rows: 0 = row r-2, 1 = row r-1, 2 = row r; column 2 is newest
        for (int r = 0; r < 3; r++) begin
          win_q[r*3]   <= win_q[r*3+1];
          win_q[r*3+1] <= win_q[r*3+2];
        end
        win_q[2] <= lb2_q[col_q];
        win_q[5] <= lb1_q[col_q];
        win_q[8] <= in_ifm;
        if (last_px) begin
          col_q  <= '0;
          row_q  <= '0;
          wcnt_q <= '0;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      fire_q      <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      v1_q        <= fire_q;
      sum_q       <= sum_d;
      out_valid   <= v1_q;
      out_ofm     <= v1_q ? sum_q : '0;
      drain_cnt_q <= (state_q == DRAIN) && !drain_cnt_q;
      frame_done  <= (state_q == DRAIN) && drain_cnt_q;
      if ((state_q == DRAIN) && in_valid) err <= 1'b1;
    end
  end
endmodule
